// File: rtl/dcache_pkg.sv
// Shared geometry, request encodings, FSM states and byte-merge helper for the L1 data cache.
package dcache_pkg;

  localparam int LINES      = 64;
  localparam int LINE_WORDS = 4;
  localparam int WO         = $clog2(LINE_WORDS);
  localparam int IW         = $clog2(LINES);
  localparam int TW         = 32 - IW - WO - 2;

  localparam logic [2:0]    RW_READ   = 3'b001;
  localparam logic [2:0]    RW_WRITE  = 3'b010;
  localparam logic [1:0]    IO_PREFIX = 2'b11;
  localparam logic [WO-1:0] LAST_WORD = WO'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_REFILL,
    S_MEMWR,
    S_IORD,
    S_DONE
  } state_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Requester-side (ex-stage memory unit) and memory-controller-side handshakes of the data cache.
interface dcache_req_if;
  logic [2:0]  rw_flag;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic [31:0] read_data;
  logic        busy;
  logic        done;

  modport master (output rw_flag, addr, write_data, write_mask,
                  input  read_data, busy, done);
  modport slave  (input  rw_flag, addr, write_data, write_mask,
                  output read_data, busy, done);
endinterface

interface dcache_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
                  input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
                  output mem_rdata, mem_ready);
endinterface

// File: rtl/dcache_line_ram.sv
// Tag, valid and data storage for the direct-mapped cache: one combinational read port,
// one byte-masked word write port, and a line-fill strobe that validates a line.
module dcache_line_ram
  import dcache_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_index,
  input  logic [WO-1:0] rd_word,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_index,
  input  logic [WO-1:0] wr_word,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_mask,
  input  logic          fill_en,
  input  logic [TW-1:0] fill_tag
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]    tag_mem  [LINES];
  logic [31:0]      data_mem [LINES*LINE_WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[{rd_index, rd_word}];

  always_comb begin
    valid_d = valid_q;
    if (fill_en) valid_d[wr_index] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag and data arrays are plain storage; only the valid bits need a defined reset state.
  always_ff @(posedge clk) begin
    if (fill_en) tag_mem[wr_index] <= fill_tag;
    if (wr_en) begin
      data_mem[{wr_index, wr_word}] <= merge_bytes(data_mem[{wr_index, wr_word}], wr_data, wr_mask);
    end
  end

endmodule

// File: rtl/dcache.sv
// Blocking direct-mapped write-through, no-write-allocate L1 data cache with IO bypass.
// Owns the request FSM, refill counter and request latches; storage lives in dcache_line_ram.
module dcache
  import dcache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  dcache_req_if.slave  req,
  dcache_mem_if.master mem
);

  state_e        state_q, state_d;
  logic [31:2]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          is_write_q, is_write_d;
  logic [WO-1:0] cnt_q, cnt_d;
  logic [31:0]   fill_word_q, fill_word_d;
  logic [31:0]   read_data_q, read_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_wmask_q, mem_wmask_d;

  logic [IW-1:0] index;
  logic [WO-1:0] word;
  logic [TW-1:0] tag;
  logic [WO-1:0] cnt_inc;
  logic          is_io, hit, beat;
  logic          rd_valid;
  logic [TW-1:0] rd_tag;
  logic [31:0]   rd_data;
  logic          wr_en, fill_en;
  logic [WO-1:0] wr_word;
  logic [31:0]   wr_data;
  logic [3:0]    wr_mask;

  assign word    = addr_q[WO+1:2];
  assign index   = addr_q[WO+IW+1:WO+2];
  assign tag     = addr_q[31:WO+IW+2];
  assign is_io   = (addr_q[31:30] == IO_PREFIX);
  assign hit     = rd_valid && (rd_tag == tag) && !is_io;
  assign beat    = mem.mem_ready && mem_req_q;
  assign cnt_inc = cnt_q + WO'(1);

  dcache_line_ram u_ram (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_word  (word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (index),
    .wr_word  (wr_word),
    .wr_data  (wr_data),
    .wr_mask  (wr_mask),
    .fill_en  (fill_en),
    .fill_tag (tag)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    is_write_d  = is_write_q;
    cnt_d       = cnt_q;
    fill_word_d = fill_word_q;
    read_data_d = read_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    wr_en       = 1'b0;
    wr_word     = word;
    wr_data     = wdata_q;
    wr_mask     = wmask_q;
    fill_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req.rw_flag == RW_READ || req.rw_flag == RW_WRITE) begin
          state_d    = S_LOOKUP;
          addr_d     = req.addr[31:2];
          wdata_d    = req.write_data;
          wmask_d    = req.write_mask;
          is_write_d = (req.rw_flag == RW_WRITE);
        end
      end
      S_LOOKUP: begin
        if (is_write_q) begin
          wr_en       = hit;
          state_d     = S_MEMWR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr_q, 2'b00};
          mem_wdata_d = wdata_q;
          mem_wmask_d = wmask_q;
        end else if (hit) begin
          read_data_d = rd_data;
          state_d     = S_DONE;
        end else if (is_io) begin
          state_d    = S_IORD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {addr_q, 2'b00};
        end else begin
          state_d    = S_REFILL;
          cnt_d      = '0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {addr_q[31:WO+2], {WO{1'b0}}, 2'b00};
        end
      end
      // Each beat lands in the array; the requested word is kept aside so read_data only moves at done.
      S_REFILL: begin
        if (beat) begin
          wr_en      = 1'b1;
          wr_word    = cnt_q;
          wr_data    = mem.mem_rdata;
          wr_mask    = 4'hF;
          cnt_d      = cnt_inc;
          mem_addr_d = {addr_q[31:WO+2], cnt_inc, 2'b00};
          if (cnt_q == word) fill_word_d = mem.mem_rdata;
          if (cnt_q == LAST_WORD) begin
            fill_en     = 1'b1;
            mem_req_d   = 1'b0;
            state_d     = S_DONE;
            read_data_d = (cnt_q == word) ? mem.mem_rdata : fill_word_q;
          end
        end
      end
      S_MEMWR: begin
        if (beat) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_IORD: begin
        if (beat) begin
          read_data_d = mem.mem_rdata;
          mem_req_d   = 1'b0;
          state_d     = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = !(state_d == S_IDLE || state_d == S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      is_write_q  <= 1'b0;
      cnt_q       <= '0;
      fill_word_q <= '0;
      read_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      is_write_q  <= is_write_d;
      cnt_q       <= cnt_d;
      fill_word_q <= fill_word_d;
      read_data_q <= read_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end

  assign req.read_data = read_data_q;
  assign req.busy      = busy_q;
  assign req.done      = done_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_wmask = mem_wmask_q;

endmodule
